// File: rtl/mul_exe_pipe.sv
// Pipelined integer multiply unit: partial products accumulated over STAGES registers.
// Define TARTARUGA_MULH_EN to build the MULH/MULHSU/MULHU high-product datapath.
package mul_exe_pkg;
  localparam int MUL_XLEN = 32;
  localparam int EXE_STAGES_MULT = 4;

  typedef enum logic [1:0] {ALU = 2'd0, MUL = 2'd1, MEM = 2'd2, CSR = 2'd3} wb_origin_e;

  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  typedef union packed {
    rtype_t      rtype;
    logic [31:0] raw;
  } instr_word_t;

  typedef struct packed {
    instr_word_t instr;
    wb_origin_e  wb_origin;
    logic        write_enable;
    logic [4:0]  addr_rd;
  } instr_t;

  typedef struct packed {
    logic                valid;
    instr_t              instr;
    logic [MUL_XLEN-1:0] data_rs1;
    logic [MUL_XLEN-1:0] data_rs2;
  } decode_to_exe_t;

  typedef struct packed {
    logic                valid;
    instr_t              instr;
    logic [MUL_XLEN-1:0] result;
    logic [MUL_XLEN-1:0] data_rs2;
    logic                branch_taken;
  } exe_to_mem_t;
endpackage

module mul_exe_pipe
  import mul_exe_pkg::*;
#(
  parameter int STAGES = EXE_STAGES_MULT,
  parameter int XLEN   = MUL_XLEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall_i,
  input  logic           flush_i,
  input  decode_to_exe_t from_decode_i,
  output exe_to_mem_t    to_mem_o,
  input  logic [4:0]     query_rs1_i,
  input  logic [4:0]     query_rs2_i,
  output logic           hazard_o,
  output logic           busy_o
);

`ifdef TARTARUGA_MULH_EN
  localparam int OPW = XLEN + 1;
  localparam int PW  = 2 * XLEN + 2;
`else
  localparam int OPW = XLEN;
  localparam int PW  = XLEN;
`endif
  // rs2 is cut into STAGES chunks; NB > OPW always, so the sign-extension below is never empty
  localparam int CH  = OPW / STAGES + 1;
  localparam int NB  = STAGES * CH;
  localparam int PPW = OPW + CH + 1;

  typedef struct packed {
    logic              valid;
    instr_t            instr;
    logic [XLEN-1:0]   data_rs2;
`ifdef TARTARUGA_MULH_EN
    logic [2:0]        func3;
`endif
    logic [OPW-1:0]    a;
    logic [NB-1:0]     b;
    logic [PW-1:0]     acc;
  } stage_t;

  stage_t         st  [STAGES];
  stage_t         adv [STAGES];
  logic [OPW-1:0] a_op;
  logic [OPW-1:0] b_op;

  // Chunk k of b times a, placed at its weight; the top chunk carries b's sign.
  function automatic logic [PW-1:0] part_prod(input logic [OPW-1:0] a,
                                              input logic [NB-1:0] b,
                                              input int k);
    logic [CH-1:0]         c;
    logic                  s;
    logic signed [PPW-1:0] ae;
    logic signed [PPW-1:0] ce;
    logic signed [PPW-1:0] p;
    logic [PW+PPW-1:0]     ext;
    c   = b[k*CH +: CH];
    s   = (k == STAGES - 1) ? c[CH-1] : 1'b0;
    ae  = {{(CH + 1){a[OPW-1]}}, a};
    ce  = {{(OPW + 1){s}}, c};
    p   = ae * ce;
    ext = {{PW{p[PPW-1]}}, p} << (k * CH);
    return ext[PW-1:0];
  endfunction

  // Next-state of every stage when the pipe advances.
  always_comb begin
`ifdef TARTARUGA_MULH_EN
    a_op = {((from_decode_i.instr.instr.rtype.func3 == 3'b001) ||
             (from_decode_i.instr.instr.rtype.func3 == 3'b010)) ?
            from_decode_i.data_rs1[XLEN-1] : 1'b0, from_decode_i.data_rs1};
    b_op = {(from_decode_i.instr.instr.rtype.func3 == 3'b001) ?
            from_decode_i.data_rs2[XLEN-1] : 1'b0, from_decode_i.data_rs2};
`else
    a_op = from_decode_i.data_rs1;
    b_op = from_decode_i.data_rs2;
`endif
    adv[0]          = '0;
    adv[0].valid    = from_decode_i.valid && (from_decode_i.instr.wb_origin == MUL);
    adv[0].instr    = from_decode_i.instr;
    adv[0].data_rs2 = from_decode_i.data_rs2;
`ifdef TARTARUGA_MULH_EN
    adv[0].func3    = from_decode_i.instr.instr.rtype.func3;
`endif
    adv[0].a        = a_op;
    adv[0].b        = {{(NB - OPW){b_op[OPW-1]}}, b_op};
    adv[0].acc      = part_prod(a_op, adv[0].b, 0);
    for (int k = 1; k < STAGES; k++) begin
      adv[k]     = st[k-1];
      adv[k].acc = st[k-1].acc + part_prod(st[k-1].a, st[k-1].b, k);
    end
  end

  // Stage registers: flush beats stall, stall freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) st[k] <= '0;
    end else if (flush_i) begin
      for (int k = 0; k < STAGES; k++) st[k].valid <= 1'b0;
    end else if (!stall_i) begin
      for (int k = 0; k < STAGES; k++) st[k] <= adv[k];
    end else begin
      for (int k = 0; k < STAGES; k++) st[k] <= st[k];
    end
  end

  // Output packet taken from the last stage.
  always_comb begin
    to_mem_o              = '0;
    to_mem_o.valid        = st[STAGES-1].valid;
    to_mem_o.instr        = st[STAGES-1].instr;
    to_mem_o.data_rs2     = st[STAGES-1].data_rs2;
    to_mem_o.branch_taken = 1'b0;
`ifdef TARTARUGA_MULH_EN
    case (st[STAGES-1].func3)
      3'b001, 3'b010, 3'b011: to_mem_o.result = st[STAGES-1].acc[2*XLEN-1:XLEN];
      default:                to_mem_o.result = st[STAGES-1].acc[XLEN-1:0];
    endcase
`else
    to_mem_o.result = st[STAGES-1].acc[XLEN-1:0];
`endif
  end

  // Busy and RAW hazard against decode's source registers.
  always_comb begin
    hazard_o = 1'b0;
    busy_o   = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      busy_o = busy_o | st[k].valid;
      if (st[k].valid && st[k].instr.write_enable && (st[k].instr.addr_rd != 5'd0) &&
          ((st[k].instr.addr_rd == query_rs1_i) || (st[k].instr.addr_rd == query_rs2_i))) begin
        hazard_o = 1'b1;
      end else begin
        hazard_o = hazard_o;
      end
    end
  end

endmodule

// File: tb/tb_mul_exe_pipe.sv
// Randomized self-checking bench for mul_exe_pipe against an in-flight queue model.
module tb_mul_exe_pipe;
  import mul_exe_pkg::*;

  localparam int STAGES = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           stall_i;
  logic           flush_i;
  decode_to_exe_t from_decode_i;
  exe_to_mem_t    to_mem_o;
  logic [4:0]     query_rs1_i;
  logic [4:0]     query_rs2_i;
  logic           hazard_o;
  logic           busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    instr_t      instr;
    logic [31:0] rs2;
    logic [31:0] res;
    int          age;
  } exp_t;
  exp_t mq[$];

  int          vt_cnt, vt_first, hz_cnt;
  logic [31:0] vt_res;

  mul_exe_pipe #(.STAGES(STAGES), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .from_decode_i(from_decode_i), .to_mem_o(to_mem_o),
    .query_rs1_i(query_rs1_i), .query_rs2_i(query_rs2_i),
    .hazard_o(hazard_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, sbu;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sbu = longint'({32'd0, b});
    p   = {32'd0, a} * {32'd0, b};
`ifdef TARTARUGA_MULH_EN
    case (f3)
      3'b001:  begin p = sa * sb;  return p[63:32]; end
      3'b010:  begin p = sa * sbu; return p[63:32]; end
      3'b011:  return p[63:32];
      default: return p[31:0];
    endcase
`else
    return p[31:0];
`endif
  endfunction

  function automatic decode_to_exe_t mk(input logic v, input wb_origin_e o, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic we,
                                        input logic [31:0] r1, input logic [31:0] r2);
    decode_to_exe_t p;
    p = '0;
    p.valid                   = v;
    p.instr.instr.raw         = $urandom();
    p.instr.instr.rtype.func3 = f3;
    p.instr.instr.rtype.rd    = rd;
    p.instr.wb_origin         = o;
    p.instr.write_enable      = we;
    p.instr.addr_rd           = rd;
    p.data_rs1                = r1;
    p.data_rs2                = r2;
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Model: packets age by one per advancing edge and are visible at age STAGES.
  task automatic model_edge();
    exp_t e;
    if (rst || flush_i) begin
      mq.delete();
    end else if (!stall_i) begin
      if (mq.size() > 0 && mq[0].age == STAGES) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (from_decode_i.valid && from_decode_i.instr.wb_origin == MUL) begin
        e.instr = from_decode_i.instr;
        e.rs2   = from_decode_i.data_rs2;
        e.res   = ref_res(from_decode_i.instr.instr.rtype.func3,
                          from_decode_i.data_rs1, from_decode_i.data_rs2);
        e.age   = 1;
        mq.push_back(e);
      end
    end
  endtask

  task automatic compare_outputs();
    logic ev, eh;
    ev = (mq.size() > 0) && (mq[0].age == STAGES);
    eh = 1'b0;
    foreach (mq[i])
      if (mq[i].instr.write_enable && mq[i].instr.addr_rd != 5'd0 &&
          (mq[i].instr.addr_rd == query_rs1_i || mq[i].instr.addr_rd == query_rs2_i)) eh = 1'b1;
    check("valid", 64'(to_mem_o.valid), 64'(ev));
    check("branch_taken", 64'(to_mem_o.branch_taken), 64'd0);
    check("busy", 64'(busy_o), 64'(mq.size() > 0));
    check("hazard", 64'(hazard_o), 64'(eh));
    if (ev) begin
      check("result", 64'(to_mem_o.result), 64'(mq[0].res));
      check("instr", 64'(to_mem_o.instr), 64'(mq[0].instr));
      check("data_rs2", 64'(to_mem_o.data_rs2), 64'(mq[0].rs2));
    end
  endtask

  task automatic run_cycle(input decode_to_exe_t p, input logic st, input logic fl,
                           input logic [4:0] q1, input logic [4:0] q2);
    from_decode_i = p;
    stall_i       = st;
    flush_i       = fl;
    query_rs1_i   = q1;
    query_rs2_i   = q2;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic track_clear();
    vt_cnt = 0; vt_first = 0; vt_res = 32'd0; hz_cnt = 0;
  endtask

  task automatic track(input int e);
    if (hazard_o) hz_cnt++;
    if (to_mem_o.valid) begin
      vt_cnt++;
      if (vt_first == 0) begin
        vt_first = e;
        vt_res   = to_mem_o.result;
      end
    end
  endtask

  decode_to_exe_t idle;
  logic           haz1;
  logic [31:0]    b2b_exp [3];

  initial begin
    idle = '0;
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    from_decode_i = '0; query_rs1_i = 5'd0; query_rs2_i = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(to_mem_o.valid), 64'd0);
    check("rst_result", 64'(to_mem_o.result), 64'd0);
    check("rst_branch", 64'(to_mem_o.branch_taken), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_hazard", 64'(hazard_o), 64'd0);
    rst = 1'b0;

    // Single MUL 7*6, latency and hazard on rd=5.
    track_clear();
    run_cycle(mk(1'b1, MUL, 3'b000, 5'd5, 1'b1, 32'd7, 32'd6), 1'b0, 1'b0, 5'd5, 5'd0);
    haz1 = hazard_o;
    track(1);
    for (int e = 2; e <= 8; e++) begin
      run_cycle(idle, 1'b0, 1'b0, 5'd5, 5'd0);
      track(e);
    end
    check("mul42_edge", 64'(vt_first), 64'd4);
    check("mul42_result", 64'(vt_res), 64'd42);
    check("mul42_count", 64'(vt_cnt), 64'd1);
    check("mul42_hazard", 64'(haz1), 64'd1);

    // Back-to-back high-product ops.
`ifdef TARTARUGA_MULH_EN
    b2b_exp[0] = 32'h4000_0000; b2b_exp[1] = 32'hFFFF_FFFE; b2b_exp[2] = 32'hFFFF_FFFF;
`else
    b2b_exp[0] = 32'h0000_0000; b2b_exp[1] = 32'h0000_0001; b2b_exp[2] = 32'hFFFF_FFFE;
`endif
    track_clear();
    run_cycle(mk(1'b1, MUL, 3'b001, 5'd1, 1'b1, 32'h8000_0000, 32'h8000_0000), 1'b0, 1'b0, 5'd0, 5'd0);
    run_cycle(mk(1'b1, MUL, 3'b011, 5'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b0, 1'b0, 5'd0, 5'd0);
    run_cycle(mk(1'b1, MUL, 3'b010, 5'd3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002), 1'b0, 1'b0, 5'd0, 5'd0);
    for (int e = 4; e <= 9; e++) begin
      run_cycle(idle, 1'b0, 1'b0, 5'd0, 5'd0);
      track(e);
      if (e <= 6) begin
        check("b2b_valid", 64'(to_mem_o.valid), 64'd1);
        check("b2b_result", 64'(to_mem_o.result), 64'(b2b_exp[e-4]));
      end
    end
    check("b2b_count", 64'(vt_cnt), 64'd3);

    // Stall for three edges after the second edge.
    track_clear();
    run_cycle(mk(1'b1, MUL, 3'b000, 5'd9, 1'b1, 32'd3, 32'd5), 1'b0, 1'b0, 5'd0, 5'd0);
    track(1);
    run_cycle(idle, 1'b0, 1'b0, 5'd0, 5'd0);
    track(2);
    for (int e = 3; e <= 5; e++) begin
      run_cycle(mk(1'b1, MUL, 3'b000, 5'd4, 1'b1, 32'd100, 32'd100), 1'b1, 1'b0, 5'd0, 5'd0);
      track(e);
    end
    for (int e = 6; e <= 10; e++) begin
      run_cycle(idle, 1'b0, 1'b0, 5'd0, 5'd0);
      track(e);
    end
    check("stall_edge", 64'(vt_first), 64'd7);
    check("stall_result", 64'(vt_res), 64'd15);
    check("stall_count", 64'(vt_cnt), 64'd1);

    // Fill then flush together with stall.
    for (int i = 1; i <= 4; i++)
      run_cycle(mk(1'b1, MUL, 3'b000, 5'(i), 1'b1, pick(), pick()), 1'b0, 1'b0, 5'd2, 5'd0);
    run_cycle(mk(1'b1, MUL, 3'b000, 5'd2, 1'b1, 32'd1, 32'd1), 1'b1, 1'b1, 5'd2, 5'd0);
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_hazard", 64'(hazard_o), 64'd0);
    track_clear();
    for (int e = 1; e <= 7; e++) begin
      run_cycle(idle, 1'b0, 1'b0, 5'd2, 5'd0);
      track(e);
    end
    check("flush_count", 64'(vt_cnt), 64'd0);

    // ALU packet is filtered; rd=0 MUL raises no hazard but still completes.
    track_clear();
    run_cycle(mk(1'b1, ALU, 3'b000, 5'd7, 1'b1, 32'd9, 32'd9), 1'b0, 1'b0, 5'd0, 5'd7);
    track(1);
    run_cycle(mk(1'b1, MUL, 3'b000, 5'd0, 1'b1, 32'd9, 32'd11), 1'b0, 1'b0, 5'd0, 5'd7);
    track(2);
    for (int e = 3; e <= 8; e++) begin
      run_cycle(idle, 1'b0, 1'b0, 5'd0, 5'd7);
      track(e);
    end
    check("filter_edge", 64'(vt_first), 64'd5);
    check("filter_result", 64'(vt_res), 64'd99);
    check("filter_count", 64'(vt_cnt), 64'd1);
    check("filter_hazard", 64'(hz_cnt), 64'd0);

    // Asynchronous reset between edges while packets are in flight.
    for (int i = 0; i < 4; i++)
      run_cycle(mk(1'b1, MUL, 3'b000, 5'd6, 1'b1, pick(), pick()), 1'b0, 1'b0, 5'd6, 5'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(to_mem_o.valid), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_hazard", 64'(hazard_o), 64'd0);
    mq.delete();
    #1 rst = 1'b0;
    track_clear();
    for (int e = 1; e <= 8; e++) begin
      run_cycle(idle, 1'b0, 1'b0, 5'd6, 5'd0);
      track(e);
    end
    check("arst_count", 64'(vt_cnt), 64'd0);

    // Random traffic with stalls, flushes and bubbles.
    for (int i = 0; i < 600; i++) begin
      run_cycle(mk($urandom_range(0, 9) != 0,
                   ($urandom_range(0, 3) != 0) ? MUL : wb_origin_e'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   pick(), pick()),
                $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 8; i++) run_cycle(idle, 1'b0, 1'b0, 5'd0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
